// File: rtl/usbfs_rx_transaction_ctrl.sv
// USB FS device receive transaction controller: OUT/SETUP token -> data -> handshake,
// with per-endpoint data toggles, endpoint-buffer forwarding, IN token and SOF reporting.
module usbfs_rx_transaction_ctrl #(
    parameter int EP_NUM      = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_PKT     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        dev_addr,
    input  logic [EP_NUM-1:0] ep_ready,
    input  logic [EP_NUM-1:0] toggle_clr,
    input  logic [3:0]        rp_pid,
    input  logic [10:0]       rp_addr,
    input  logic              rp_byte_en,
    input  logic [7:0]        rp_byte,
    input  logic              rp_fin,
    input  logic              rp_okay,
    output logic [3:0]        ob_ep,
    output logic              ob_setup,
    output logic              ob_byte_en,
    output logic [7:0]        ob_byte,
    output logic              ob_commit,
    output logic              ob_abort,
    output logic              hs_req,
    output logic [3:0]        hs_pid,
    output logic              in_tok,
    output logic [3:0]        in_ep,
    output logic              sof,
    output logic [10:0]       frame_num,
    output logic              busy
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = $clog2(MAX_PKT + 2);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CMAX  = CW'(MAX_PKT);
    localparam logic [CW-1:0] COVF  = CW'(MAX_PKT + 1);
    localparam logic [4:0]    EPLIM = 5'(EP_NUM);

    typedef enum logic [1:0] {IDLE, WAIT_DATA, RECV_DATA} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [EP_NUM-1:0] tog_q, tog_d;

    logic [3:0]  ob_ep_d, hs_pid_d, in_ep_d;
    logic        ob_setup_d, ob_byte_en_d, ob_commit_d, ob_abort_d;
    logic        hs_req_d, in_tok_d, sof_d;
    logic [7:0]  ob_byte_d;
    logic [10:0] frame_d;

    logic [3:0] tok_ep;
    logic       tok_match, tog_cur, rdy_cur, is_data, end_pkt, upd, upd_val;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        cnt_d        = cnt_q;
        ob_ep_d      = ob_ep;
        ob_setup_d   = ob_setup;
        ob_byte_d    = ob_byte;
        hs_pid_d     = hs_pid;
        in_ep_d      = in_ep;
        frame_d      = frame_num;
        ob_byte_en_d = 1'b0;
        ob_commit_d  = 1'b0;
        ob_abort_d   = 1'b0;
        hs_req_d     = 1'b0;
        in_tok_d     = 1'b0;
        sof_d        = 1'b0;
        end_pkt      = 1'b0;
        upd          = 1'b0;
        upd_val      = 1'b0;
        tog_cur      = 1'b0;
        rdy_cur      = 1'b0;

        tok_ep    = rp_addr[10:7];
        tok_match = (rp_addr[6:0] == dev_addr) && ({1'b0, tok_ep} < EPLIM);
        is_data   = (rp_pid == PID_DATA0) || (rp_pid == PID_DATA1);

        for (int i = 0; i < EP_NUM; i++) begin
            if (ob_ep == i[3:0]) begin
                tog_cur = tog_q[i];
                rdy_cur = ep_ready[i];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (rp_fin && rp_okay) begin
                    if (rp_pid == PID_SOF) begin
                        sof_d   = 1'b1;
                        frame_d = rp_addr;
                    end else if (tok_match && rp_pid == PID_IN) begin
                        in_tok_d = 1'b1;
                        in_ep_d  = tok_ep;
                    end else if (tok_match &&
                                 (rp_pid == PID_OUT || rp_pid == PID_SETUP)) begin
                        ob_ep_d    = tok_ep;
                        ob_setup_d = (rp_pid == PID_SETUP);
                        timer_d    = '0;
                        cnt_d      = '0;
                        state_d    = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                timer_d = timer_q + 1'b1;
                if (rp_fin) begin
                    end_pkt = 1'b1;
                end else if (rp_byte_en) begin
                    ob_byte_en_d = 1'b1;
                    ob_byte_d    = rp_byte;
                    cnt_d        = CW'(1);
                    state_d      = RECV_DATA;
                end else if (timer_q == TMAX) begin
                    state_d = IDLE;
                end
            end
            RECV_DATA: begin
                if (rp_fin) begin
                    end_pkt = 1'b1;
                end else if (rp_byte_en) begin
                    if (cnt_q < CMAX) begin
                        ob_byte_en_d = 1'b1;
                        ob_byte_d    = rp_byte;
                    end
                    if (cnt_q != COVF) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Packet end: the data packet is judged, never re-decoded as a token
        if (end_pkt) begin
            state_d = IDLE;
            if (!rp_okay || !is_data || cnt_q > CMAX) begin
                ob_abort_d = 1'b1;
            end else if (ob_setup && rp_pid == PID_DATA1) begin
                ob_abort_d = 1'b1;
            end else if (!rdy_cur) begin
                ob_abort_d = 1'b1;
                hs_req_d   = 1'b1;
                hs_pid_d   = PID_NAK;
            end else if (ob_setup) begin
                ob_commit_d = 1'b1;
                hs_req_d    = 1'b1;
                hs_pid_d    = PID_ACK;
                upd         = 1'b1;
                upd_val     = 1'b1;
            end else if (rp_pid[3] == tog_cur) begin
                ob_commit_d = 1'b1;
                hs_req_d    = 1'b1;
                hs_pid_d    = PID_ACK;
                upd         = 1'b1;
                upd_val     = ~tog_cur;
            end else begin
                ob_abort_d = 1'b1;
                hs_req_d   = 1'b1;
                hs_pid_d   = PID_ACK;
            end
        end

        tog_d = tog_q;
        for (int i = 0; i < EP_NUM; i++) begin
            if (toggle_clr[i]) tog_d[i] = 1'b0;
            else if (upd && ob_ep == i[3:0]) tog_d[i] = upd_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            cnt_q      <= '0;
            tog_q      <= '0;
            ob_ep      <= '0;
            ob_setup   <= 1'b0;
            ob_byte_en <= 1'b0;
            ob_byte    <= '0;
            ob_commit  <= 1'b0;
            ob_abort   <= 1'b0;
            hs_req     <= 1'b0;
            hs_pid     <= '0;
            in_tok     <= 1'b0;
            in_ep      <= '0;
            sof        <= 1'b0;
            frame_num  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            tog_q      <= tog_d;
            ob_ep      <= ob_ep_d;
            ob_setup   <= ob_setup_d;
            ob_byte_en <= ob_byte_en_d;
            ob_byte    <= ob_byte_d;
            ob_commit  <= ob_commit_d;
            ob_abort   <= ob_abort_d;
            hs_req     <= hs_req_d;
            hs_pid     <= hs_pid_d;
            in_tok     <= in_tok_d;
            in_ep      <= in_ep_d;
            sof        <= sof_d;
            frame_num  <= frame_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule
